fb_write_arbiter: RTL and testbench

// - Downstream of the trail generator: accepts single-pixel frame-buffer writes (data/addr/we pulse) and commits them to the off-chip SRAM frame buffer.
// - Shares the SRAM with the VGA fetch path. VGA reads have strict priority; trail writes are buffered in a small FIFO and drained in free slots.
// - Reports overflow so gameplay logic can detect lost trail segments.

---
 rtl/tron_pkg.sv | 20 ++
 rtl/fb_wr_fifo.sv | 74 +++++++
 rtl/fb_write_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_fb_write_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tron_pkg.sv
// Shared Tron game definitions used by the trail generator, the VGA fetch
// path and the frame-buffer write arbiter.
//   FB_ADDR_W      : SRAM word address width
//   FB_DATA_W      : SRAM word width
//   fb_arb_state_t : frame-buffer arbiter FSM states
package tron_pkg;

  localparam int FB_ADDR_W = 20;
  localparam int FB_DATA_W = 16;

  typedef enum logic [2:0] {
    FB_IDLE     = 3'd0,
    FB_RD_ADDR  = 3'd1,
    FB_RD_CAP   = 3'd2,
    FB_WR_SETUP = 3'd3,
    FB_WR_PULSE = 3'd4,
    FB_WR_HOLD  = 3'd5
  } fb_arb_state_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous write-buffer FIFO for the frame-buffer arbiter.
// Ports:
//   Clk, Reset_n   : clock, asynchronous active-low reset
//   push/push_data : enqueue request; ignored while full
//   pop            : dequeue request; ignored while empty
//   head           : word at the head of the queue (valid while !empty)
//   full, empty    : registered status flags derived from the occupancy count
//   count          : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap for free.
module fb_wr_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 36,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;

  // A push while full is a drop, even if a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + 1'b1;
    end else if (!do_push && do_pop) begin
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Frame-buffer SRAM arbiter. Trail-generator pixel writes are buffered in a
// small FIFO and committed to the SRAM in slots left free by the VGA fetch
// path, which always has priority. A sticky flag reports dropped writes.
// Ports:
//   Clk, Reset_n                 : clock, asynchronous active-low reset
//   wr_data/wr_addr/wr_we        : one-cycle pixel write requests
//   wr_full                      : write buffer full (registered)
//   overflow                     : sticky, a write was dropped
//   vga_req/vga_addr             : read request, held until vga_valid
//   vga_data/vga_valid           : read data and one-cycle completion pulse
//   sram_addr/sram_dq_out/_oe    : SRAM address and write-data drive
//   sram_dq_in                   : SRAM read data
//   sram_ce_n/oe_n/we_n/ub_n/lb_n: SRAM strobes, active low
// Read : IDLE -> RD_ADDR -> RD_CAP -> IDLE(vga_valid), oe_n low for 2 cycles.
// Write: IDLE(pop) -> WR_SETUP -> WR_PULSE(we_n low) -> WR_HOLD -> IDLE.
// Every SRAM-facing output is a register loaded on entry to a state, so the
// strobes are glitch-free and oe_n/dq_oe are separated by the IDLE cycle.
module fb_write_arbiter
  import tron_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int DATA_W     = FB_DATA_W
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_we,
  output logic              wr_full,
  output logic              overflow,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_valid,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  localparam int WORD_W = ADDR_W + DATA_W;

  fb_arb_state_t state;
  fb_arb_state_t state_nxt;

  logic [WORD_W-1:0]              fifo_head;
  logic                           fifo_empty;
  logic                           fifo_pop;
  // Occupancy is only needed inside the FIFO for its flags.
  logic [$clog2(FIFO_DEPTH):0]    unused_fifo_count;

  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] dq_nxt;
  logic              dq_oe_nxt;
  logic              oe_n_nxt;
  logic              we_n_nxt;
  logic [DATA_W-1:0] vga_data_nxt;
  logic              vga_valid_nxt;

  // Chip always selected, full 16-bit words only.
  assign sram_ce_n = 1'b0;
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;

  fb_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .push      (wr_we),
    .push_data ({wr_addr, wr_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (wr_full),
    .empty     (fifo_empty),
    .count     (unused_fifo_count)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= FB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus the values every output register takes on entry to it.
  always_comb begin
    state_nxt     = state;
    addr_nxt      = sram_addr;
    dq_nxt        = sram_dq_out;
    dq_oe_nxt     = sram_dq_oe;
    oe_n_nxt      = sram_oe_n;
    we_n_nxt      = sram_we_n;
    vga_data_nxt  = vga_data;
    vga_valid_nxt = 1'b0;
    fifo_pop      = 1'b0;
    case (state)
      FB_IDLE: begin
        if (vga_req) begin
          state_nxt = FB_RD_ADDR;
          addr_nxt  = vga_addr;
          oe_n_nxt  = 1'b0;
          dq_oe_nxt = 1'b0;
        end else if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = FB_WR_SETUP;
          addr_nxt  = fifo_head[DATA_W +: ADDR_W];
          dq_nxt    = fifo_head[DATA_W-1:0];
          dq_oe_nxt = 1'b1;
          we_n_nxt  = 1'b1;
        end
      end
      FB_RD_ADDR: begin
        state_nxt = FB_RD_CAP;
      end
      FB_RD_CAP: begin
        // Address and oe_n have been stable for two cycles; capture now.
        state_nxt     = FB_IDLE;
        vga_data_nxt  = sram_dq_in;
        vga_valid_nxt = 1'b1;
        oe_n_nxt      = 1'b1;
      end
      FB_WR_SETUP: begin
        state_nxt = FB_WR_PULSE;
        we_n_nxt  = 1'b0;
      end
      FB_WR_PULSE: begin
        state_nxt = FB_WR_HOLD;
        we_n_nxt  = 1'b1;
      end
      FB_WR_HOLD: begin
        // Data held one cycle past the we_n rising edge before release.
        state_nxt = FB_IDLE;
        dq_oe_nxt = 1'b0;
      end
      default: begin
        state_nxt = FB_IDLE;
        oe_n_nxt  = 1'b1;
        we_n_nxt  = 1'b1;
        dq_oe_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sram_addr  <= '0;
      sram_dq_oe <= 1'b0;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      vga_data   <= '0;
      vga_valid  <= 1'b0;
    end else begin
      sram_addr  <= addr_nxt;
      sram_dq_oe <= dq_oe_nxt;
      sram_oe_n  <= oe_n_nxt;
      sram_we_n  <= we_n_nxt;
      vga_data   <= vga_data_nxt;
      vga_valid  <= vga_valid_nxt;
    end
  end

  // Write data is only meaningful while sram_dq_oe is high.
  always_ff @(posedge Clk) begin
    sram_dq_out <= dq_nxt;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      overflow <= 1'b0;
    end else if (wr_we && wr_full) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
module tb_fb_write_arbiter;

  localparam int DEPTH = 8;
  localparam int AW    = 20;
  localparam int DW    = 16;
  localparam int WW    = AW + DW;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [AW-1:0] wr_addr = '0;
  logic          wr_we = 1'b0;
  logic          wr_full, overflow;
  logic          vga_req = 1'b0;
  logic [AW-1:0] vga_addr = '0;
  logic [DW-1:0] vga_data;
  logic          vga_valid;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dq_out;
  logic          sram_dq_oe;
  logic [DW-1:0] sram_dq_in;
  logic          sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  fb_write_arbiter dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .wr_data(wr_data), .wr_addr(wr_addr), .wr_we(wr_we),
    .wr_full(wr_full), .overflow(overflow),
    .vga_req(vga_req), .vga_addr(vga_addr),
    .vga_data(vga_data), .vga_valid(vga_valid),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  always #10 Clk = ~Clk;

  // Asynchronous SRAM model: reads combinational while oe_n is low.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  assign sram_dq_in = sram_oe_n ? 16'hDEAD : mem[sram_addr];

  int n_chk = 0;
  int n_pass = 0;

  // Read-region table (addr bit 19 set, plus 0x12345); writes go to 0x2xxxx/0x3xxxx.
  logic [AW-1:0] rd_addr [8];
  logic [DW-1:0] rd_val  [8];

  // Reference model: queue of accepted, not-yet-started writes (FIFO order),
  // expected sticky overflow, and tracking of the 3-cycle write window.
  logic [WW-1:0] expq [$];
  logic [WW-1:0] cur_w = '0;
  logic [WW-1:0] pend_word = '0;
  logic          pend_push = 1'b0;
  logic          pend_drop = 1'b0;
  logic          ovf_exp = 1'b0;
  logic          oe_q = 1'b0;
  int            win = 0;
  int            nwr = 0;

  always @(negedge Clk) begin
    if (!Reset_n) begin
      expq.delete();
      pend_push = 1'b0;
      pend_drop = 1'b0;
      ovf_exp   = 1'b0;
      win       = 0;
    end else begin
      if (!sram_we_n) mem[sram_addr] = sram_dq_out;
      n_chk++;
      if (!sram_oe_n && sram_dq_oe) $display("FAIL bus_conflict: oe_n=0 and dq_oe=1 at %0t", $time);
      else n_pass++;
      if (pend_drop) ovf_exp = 1'b1;
      if (sram_dq_oe && !oe_q) begin
        win = 1;
        n_chk++;
        if (expq.size() == 0) begin
          $display("FAIL write_unexpected: write of %h started with empty model queue", {sram_addr, sram_dq_out});
        end else begin
          cur_w = expq.pop_front();
          nwr++;
          if ({sram_addr, sram_dq_out} !== cur_w)
            $display("FAIL write_order: got %h want %h", {sram_addr, sram_dq_out}, cur_w);
          else n_pass++;
        end
      end else if (sram_dq_oe) begin
        win++;
        n_chk++;
        if ({sram_addr, sram_dq_out} !== cur_w)
          $display("FAIL write_stable: got %h want %h", {sram_addr, sram_dq_out}, cur_w);
        else n_pass++;
      end
      if (!sram_dq_oe && oe_q) begin
        n_chk++;
        if (win != 3) $display("FAIL write_window: dq_oe high %0d cycles want 3", win);
        else n_pass++;
      end
      n_chk++;
      if (sram_we_n !== !(sram_dq_oe && win == 2))
        $display("FAIL we_n_timing: we_n=%b win=%0d dq_oe=%b", sram_we_n, win, sram_dq_oe);
      else n_pass++;
      if (pend_push) expq.push_back(pend_word);
      pend_push = 1'b0;
      pend_drop = 1'b0;
      n_chk++;
      if (wr_full !== (expq.size() == DEPTH))
        $display("FAIL wr_full: got %b want %b (occ %0d)", wr_full, expq.size() == DEPTH, expq.size());
      else n_pass++;
      n_chk++;
      if (overflow !== ovf_exp) $display("FAIL overflow_flag: got %b want %b", overflow, ovf_exp);
      else n_pass++;
      // Decide the fate of the write the next edge will sample.
      if (wr_we) begin
        if (expq.size() == DEPTH) pend_drop = 1'b1;
        else begin
          pend_push = 1'b1;
          pend_word = {wr_addr, wr_data};
        end
      end
    end
    oe_q = Reset_n ? sram_dq_oe : 1'b0;
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((expq.size() != 0 || sram_dq_oe || pend_push) && n < 200) begin
      step();
      n++;
    end
    n_chk++;
    if (n >= 200) $display("FAIL %s_drain: %0d writes still pending after 200 cycles", tag, expq.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (2) step();
    n_chk++;
    if ({sram_ce_n, sram_ub_n, sram_lb_n, sram_oe_n, sram_we_n, sram_dq_oe, wr_full, overflow, vga_valid} !== 9'b000110000)
      $display("FAIL reset_strobes: got %b want 000110000",
               {sram_ce_n, sram_ub_n, sram_lb_n, sram_oe_n, sram_we_n, sram_dq_oe, wr_full, overflow, vga_valid});
    else n_pass++;
    n_chk++;
    if (vga_data !== '0) $display("FAIL reset_vga_data: got %h want 0", vga_data);
    else n_pass++;
    n_chk++;
    if (sram_addr !== '0) $display("FAIL reset_sram_addr: got %h want 0", sram_addr);
    else n_pass++;
    Reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_chk++;
      if ({vga_valid, sram_oe_n, sram_we_n, sram_dq_oe, wr_full, overflow} !== 6'b011000)
        $display("FAIL idle_quiet: got %b want 011000",
                 {vga_valid, sram_oe_n, sram_we_n, sram_dq_oe, wr_full, overflow});
      else n_pass++;
    end
  endtask

  task automatic test_single_write();
    logic [8:1] oe_h, wen_h;
    logic       stable;
    wr_we = 1'b1; wr_addr = 20'h00A5C; wr_data = 16'h0F0F;
    stable = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      step();
      if (t == 1) wr_we = 1'b0;
      oe_h[t]  = sram_dq_oe;
      wen_h[t] = sram_we_n;
      if (sram_dq_oe && (sram_addr !== 20'h00A5C || sram_dq_out !== 16'h0F0F)) stable = 1'b0;
    end
    // Word lands in the FIFO on the first edge, is popped on the second.
    n_chk++;
    if (oe_h !== 8'b0000_1110) $display("FAIL single_dq_oe: got %b want 00001110", oe_h);
    else n_pass++;
    n_chk++;
    if (wen_h !== 8'b1111_1011) $display("FAIL single_we_n: got %b want 11111011", wen_h);
    else n_pass++;
    n_chk++;
    if (!stable) $display("FAIL single_addr_data: addr/data not 00a5c/0f0f while driven");
    else n_pass++;
    wait_drain("single");
  endtask

  task automatic test_read();
    logic [5:1] oen_h, vld_h;
    vga_addr = 20'h12345; vga_req = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      step();
      oen_h[t] = sram_oe_n;
      vld_h[t] = vga_valid;
      if (vga_valid) begin
        vga_req = 1'b0;
        n_chk++;
        if (vga_data !== 16'h1234) $display("FAIL read_data: got %h want 1234", vga_data);
        else n_pass++;
      end
    end
    n_chk++;
    if (oen_h !== 5'b11100) $display("FAIL read_oe_n: got %b want 11100", oen_h);
    else n_pass++;
    n_chk++;
    if (vld_h !== 5'b00100) $display("FAIL read_latency: got %b want 00100", vld_h);
    else n_pass++;
    n_chk++;
    if (vga_data !== 16'h1234) $display("FAIL read_hold: got %h want 1234", vga_data);
    else n_pass++;
  endtask

  task automatic test_contention();
    int tv, tw;
    tv = -1; tw = -1;
    wr_we = 1'b1; wr_addr = 20'h2ABCD; wr_data = 16'($urandom);
    vga_req = 1'b1; vga_addr = rd_addr[2];
    for (int t = 1; t <= 20; t++) begin
      step();
      if (t == 1) wr_we = 1'b0;
      if (vga_valid && tv < 0) begin
        tv = t;
        vga_req = 1'b0;
        n_chk++;
        if (vga_data !== rd_val[2]) $display("FAIL contention_data: got %h want %h", vga_data, rd_val[2]);
        else n_pass++;
      end
      if (sram_dq_oe && tw < 0) tw = t;
    end
    n_chk++;
    if (tv != 3) $display("FAIL contention_read_first: vga_valid at %0d want 3", tv);
    else n_pass++;
    n_chk++;
    if (tw != 4) $display("FAIL contention_write_after: write start at %0d want 4", tw);
    else n_pass++;
    wait_drain("contention");
  endtask

  task automatic test_random();
    int held, idx, reads;
    held = 0; idx = 0; reads = 0;
    for (int c = 0; c < 600; c++) begin
      wr_we = ($urandom_range(0, 7) == 0);
      wr_addr = {3'b001, 17'($urandom)};
      wr_data = 16'($urandom);
      if (!vga_req && $urandom_range(0, 7) == 0) begin
        idx = $urandom_range(0, 7);
        vga_addr = rd_addr[idx];
        vga_req = 1'b1;
        held = 0;
      end
      step();
      if (vga_req) held++;
      if (vga_valid) begin
        n_chk++;
        if (!vga_req) $display("FAIL rand_spurious_valid: vga_valid with no request");
        else if (vga_data !== rd_val[idx])
          $display("FAIL rand_read_data: addr %h got %h want %h", vga_addr, vga_data, rd_val[idx]);
        else n_pass++;
        vga_req = 1'b0;
        reads++;
      end else if (vga_req && held > 40) begin
        n_chk++;
        $display("FAIL rand_read_timeout: no vga_valid after %0d cycles", held);
        vga_req = 1'b0;
      end
    end
    wr_we = 1'b0;
    if (vga_req) begin
      for (int i = 0; i < 20 && !vga_valid; i++) step();
      vga_req = 1'b0;
    end
    n_chk++;
    if (reads < 20) $display("FAIL rand_reads: only %0d reads completed, want >= 20", reads);
    else n_pass++;
    wait_drain("random");
  endtask

  task automatic test_overflow();
    int base, n;
    n_chk++;
    if (overflow !== ovf_exp) $display("FAIL ovf_before: got %b want %b", overflow, ovf_exp);
    else n_pass++;
    base = nwr;
    vga_req = 1'b1; vga_addr = rd_addr[1];
    for (int i = 0; i < 9; i++) begin
      wr_we = 1'b1; wr_addr = 20'h30000 + 20'(i); wr_data = 16'hA000 + 16'(i);
      step();
      n_chk++;
      if (wr_full !== (i >= 7)) $display("FAIL ovf_full_push%0d: got %b want %b", i + 1, wr_full, i >= 7);
      else n_pass++;
    end
    wr_we = 1'b0;
    step();
    n_chk++;
    if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow);
    else n_pass++;
    n = 0;
    while (!vga_valid && n < 10) begin
      step();
      n++;
    end
    vga_req = 1'b0;
    wait_drain("overflow");
    n_chk++;
    if (nwr - base != 8) $display("FAIL ovf_drain_count: got %0d writes want 8", nwr - base);
    else n_pass++;
    n_chk++;
    if (wr_full !== 1'b0 || overflow !== 1'b1)
      $display("FAIL ovf_after_drain: wr_full=%b overflow=%b want 0 1", wr_full, overflow);
    else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    int n, bad;
    for (int i = 0; i < 3; i++) begin
      wr_we = 1'b1; wr_addr = 20'h3F000 + 20'(i); wr_data = 16'h5500 + 16'(i);
      step();
    end
    wr_we = 1'b0;
    n = 0;
    while (sram_we_n && n < 20) begin
      step();
      n++;
    end
    n_chk++;
    if (n >= 20) $display("FAIL rst_mid_reach: we_n never went low");
    else n_pass++;
    Reset_n = 1'b0;
    #1;
    n_chk++;
    if ({sram_we_n, sram_dq_oe, sram_oe_n, wr_full, overflow} !== 5'b10100)
      $display("FAIL rst_mid_async: we_n,dq_oe,oe_n,full,ovf got %b want 10100",
               {sram_we_n, sram_dq_oe, sram_oe_n, wr_full, overflow});
    else n_pass++;
    repeat (2) step();
    Reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sram_dq_oe || !sram_we_n) bad++;
    end
    n_chk++;
    if (bad != 0) $display("FAIL rst_mid_no_write: %0d cycles of write activity want 0", bad);
    else n_pass++;
  endtask

  initial begin
    rd_addr[0] = 20'h12345;
    rd_val[0]  = 16'h1234;
    for (int i = 1; i < 8; i++) begin
      rd_addr[i] = 20'h80000 | 20'(i << 8) | 20'($urandom_range(0, 255));
      rd_val[i]  = 16'($urandom);
    end
    for (int i = 0; i < 8; i++) mem[rd_addr[i]] = rd_val[i];
    test_reset();
    test_single_write();
    test_read();
    test_contention();
    test_random();
    test_overflow();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
